// File: rtl/controlador_elevador.sv
// Four-floor elevator controller. It serves pending floor requests in collective (SCAN) order,
// drives the motor and door, and clears each served request in the external request memory.
module controlador_elevador #(
    parameter int TEMPO_ANDAR = 8,
    parameter int TEMPO_PORTA = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       terreo,
    input  logic       primeiro_andar,
    input  logic       segundo_andar,
    input  logic       terceiro_andar,
    output logic [1:0] endereco,
    output logic       escrita,
    output logic       dado,
    output logic       motor_subir,
    output logic       motor_descer,
    output logic       porta_aberta,
    output logic [1:0] andar_atual,
    output logic       direcao
);

    localparam int CNT_MAX = (TEMPO_ANDAR > TEMPO_PORTA) ? TEMPO_ANDAR : TEMPO_PORTA;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] CNT_ANDAR = CW'(TEMPO_ANDAR - 1);
    localparam logic [CW-1:0] CNT_PORTA = CW'(TEMPO_PORTA - 1);

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        MOVENDO = 2'd1,
        LIMPAR  = 2'd2,
        PORTA   = 2'd3
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [1:0]    andar_q, andar_d;
    logic          direcao_q, direcao_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          escrita_q, escrita_d;
    logic          subir_q, subir_d;
    logic          descer_q, descer_d;
    logic          porta_q, porta_d;

    logic [3:0] req;
    logic [3:0] acima_v, abaixo_v, alem_v;
    logic [1:0] nf;
    logic       acima, abaixo, aqui, req_nf, alem;

    assign req = {terceiro_andar, segundo_andar, primeiro_andar, terreo};

    // Floor reached at the end of the current leg; saturates so the car can never leave 0..3.
    always_comb begin
        nf = andar_q;
        if (direcao_q && andar_q != 2'd3) begin
            nf = andar_q + 2'd1;
        end else if (!direcao_q && andar_q != 2'd0) begin
            nf = andar_q - 2'd1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_andar
            assign acima_v[gi]  = req[gi] && (2'(gi) > andar_q);
            assign abaixo_v[gi] = req[gi] && (2'(gi) < andar_q);
            assign alem_v[gi]   = req[gi] && (direcao_q ? (2'(gi) > nf) : (2'(gi) < nf));
        end
    endgenerate

    assign acima  = |acima_v;
    assign abaixo = |abaixo_v;
    assign alem   = |alem_v;
    assign aqui   = req[andar_q];
    assign req_nf = req[nf];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado_q  <= PARADO;
            andar_q   <= 2'd0;
            direcao_q <= 1'b1;
            cnt_q     <= '0;
            escrita_q <= 1'b0;
            subir_q   <= 1'b0;
            descer_q  <= 1'b0;
            porta_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            andar_q   <= andar_d;
            direcao_q <= direcao_d;
            cnt_q     <= cnt_d;
            escrita_q <= escrita_d;
            subir_q   <= subir_d;
            descer_q  <= descer_d;
            porta_q   <= porta_d;
        end
    end

    // Output registers are loaded with the values that belong to the state being entered.
    always_comb begin
        estado_d  = estado_q;
        andar_d   = andar_q;
        direcao_d = direcao_q;
        cnt_d     = cnt_q;
        escrita_d = 1'b0;
        subir_d   = 1'b0;
        descer_d  = 1'b0;
        porta_d   = 1'b0;

        case (estado_q)
            PARADO: begin
                if (aqui) begin
                    estado_d  = LIMPAR;
                    escrita_d = 1'b1;
                end else if (acima && (direcao_q || !abaixo)) begin
                    estado_d  = MOVENDO;
                    direcao_d = 1'b1;
                    cnt_d     = CNT_ANDAR;
                    subir_d   = 1'b1;
                end else if (abaixo) begin
                    estado_d  = MOVENDO;
                    direcao_d = 1'b0;
                    cnt_d     = CNT_ANDAR;
                    descer_d  = 1'b1;
                end
            end

            MOVENDO: begin
                if (cnt_q == '0) begin
                    andar_d = nf;
                    if (req_nf) begin
                        estado_d  = LIMPAR;
                        escrita_d = 1'b1;
                    end else if (alem) begin
                        cnt_d    = CNT_ANDAR;
                        subir_d  = direcao_q;
                        descer_d = !direcao_q;
                    end else begin
                        estado_d = PARADO;
                    end
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    subir_d  = direcao_q;
                    descer_d = !direcao_q;
                end
            end

            LIMPAR: begin
                estado_d = PORTA;
                cnt_d    = CNT_PORTA;
                porta_d  = 1'b1;
            end

            PORTA: begin
                if (cnt_q == '0) begin
                    estado_d = PARADO;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    porta_d = 1'b1;
                end
            end

            default: begin
                estado_d = PARADO;
            end
        endcase
    end

    assign endereco     = andar_q;
    assign dado         = 1'b0;
    assign escrita      = escrita_q;
    assign motor_subir  = subir_q;
    assign motor_descer = descer_q;
    assign porta_aberta = porta_q;
    assign andar_atual  = andar_q;
    assign direcao      = direcao_q;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(subir_q && descer_q));
            assert (!((subir_q || descer_q) && porta_q));
            assert (!escrita_q || estado_q == LIMPAR);
        end
    end

endmodule

// File: tb/tb_controlador_elevador.sv
// Bench for controlador_elevador: models the request memory, replays a per-cycle vector table
// and runs hand-written reset sequences.
module tb_controlador_elevador;

    logic       clk;
    logic       reset_n;
    logic       terreo, primeiro_andar, segundo_andar, terceiro_andar;
    logic [1:0] endereco;
    logic       escrita, dado, motor_subir, motor_descer, porta_aberta;
    logic [1:0] andar_atual;
    logic       direcao;

    logic [3:0] req_mem;
    logic [3:0] set_mask;
    logic [3:0] clr_mask;
    logic       mem_flush;

    int checks = 0;
    int errors = 0;

    controlador_elevador #(.TEMPO_ANDAR(8), .TEMPO_PORTA(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .terreo         (terreo),
        .primeiro_andar (primeiro_andar),
        .segundo_andar  (segundo_andar),
        .terceiro_andar (terceiro_andar),
        .endereco       (endereco),
        .escrita        (escrita),
        .dado           (dado),
        .motor_subir    (motor_subir),
        .motor_descer   (motor_descer),
        .porta_aberta   (porta_aberta),
        .andar_atual    (andar_atual),
        .direcao        (direcao)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request memory: the controller clears a bit by writing dado at endereco; the bench sets bits.
    assign clr_mask = (escrita && !dado) ? (4'b0001 << endereco) : 4'b0000;
    always @(posedge clk) begin
        if (mem_flush) req_mem <= 4'b0000;
        else           req_mem <= (req_mem & ~clr_mask) | set_mask;
    end
    assign terreo         = req_mem[0];
    assign primeiro_andar = req_mem[1];
    assign segundo_andar  = req_mem[2];
    assign terceiro_andar = req_mem[3];

    typedef struct {
        logic [3:0] set;
        int         n;
        logic       esc;
        logic       ms;
        logic       md;
        logic       pa;
        logic [1:0] andar;
        logic       dir;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] set, input int n, input logic esc, input logic ms,
                       input logic md, input logic pa, input logic [1:0] andar, input logic dir);
        vec_t v;
        v.set = set; v.n = n; v.esc = esc; v.ms = ms; v.md = md; v.pa = pa;
        v.andar = andar; v.dir = dir;
        tbl.push_back(v);
    endtask

    // Expected vector order: escrita, motor_subir, motor_descer, porta_aberta, andar, direcao, endereco, dado.
    task automatic check_out(input string name, input logic esc, input logic ms, input logic md,
                             input logic pa, input logic [1:0] andar, input logic dir);
        logic [9:0] got, exp;
        got = {escrita, motor_subir, motor_descer, porta_aberta, andar_atual, direcao, endereco, dado};
        exp = {esc, ms, md, pa, andar, dir, andar, 1'b0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got esc/sub/desc/porta/andar/dir/end/dado=%b required %b",
                     name, $time, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        reset_n   = 1'b1;
        set_mask  = 4'b0000;
        mem_flush = 1'b1;

        // Asynchronous reset before any clock edge.
        #1 reset_n = 1'b0;
        #1 check_out("reset_async", 0, 0, 0, 0, 2'd0, 1'b1);
        $display("reset applied at %0t", $time);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        mem_flush = 1'b0;

        // Scenario: request at current floor 0.
        add(4'b0001, 1, 0,0,0,0, 2'd0, 1);
        add(4'b0000, 1, 1,0,0,0, 2'd0, 1);
        add(4'b0000, 4, 0,0,0,1, 2'd0, 1);
        add(4'b0000, 2, 0,0,0,0, 2'd0, 1);
        // Scenario: floors 1 and 2 from floor 0, stopping at each.
        add(4'b0110, 1, 0,0,0,0, 2'd0, 1);
        add(4'b0000, 8, 0,1,0,0, 2'd0, 1);
        add(4'b0000, 1, 1,0,0,0, 2'd1, 1);
        add(4'b0000, 4, 0,0,0,1, 2'd1, 1);
        add(4'b0000, 1, 0,0,0,0, 2'd1, 1);
        add(4'b0000, 8, 0,1,0,0, 2'd1, 1);
        add(4'b0000, 1, 1,0,0,0, 2'd2, 1);
        add(4'b0000, 4, 0,0,0,1, 2'd2, 1);
        add(4'b0000, 1, 0,0,0,0, 2'd2, 1);
        // Scenario: at floor 2 going up, requests at 3 and 0: 3 first, then down to 0.
        add(4'b1001, 1, 0,0,0,0, 2'd2, 1);
        add(4'b0000, 8, 0,1,0,0, 2'd2, 1);
        add(4'b0000, 1, 1,0,0,0, 2'd3, 1);
        add(4'b0000, 4, 0,0,0,1, 2'd3, 1);
        add(4'b0000, 1, 0,0,0,0, 2'd3, 1);
        add(4'b0000, 8, 0,0,1,0, 2'd3, 0);
        add(4'b0000, 8, 0,0,1,0, 2'd2, 0);
        add(4'b0000, 8, 0,0,1,0, 2'd1, 0);
        add(4'b0000, 1, 1,0,0,0, 2'd0, 0);
        add(4'b0000, 4, 0,0,0,1, 2'd0, 0);
        add(4'b0000, 1, 0,0,0,0, 2'd0, 0);
        // Scenario: floor 0 to 3 (direction flips back up), plus re-request while door open.
        add(4'b1000, 1, 0,0,0,0, 2'd0, 0);
        add(4'b0000, 8, 0,1,0,0, 2'd0, 1);
        add(4'b0000, 8, 0,1,0,0, 2'd1, 1);
        add(4'b0000, 8, 0,1,0,0, 2'd2, 1);
        add(4'b0000, 1, 1,0,0,0, 2'd3, 1);
        add(4'b0000, 2, 0,0,0,1, 2'd3, 1);
        add(4'b1000, 1, 0,0,0,1, 2'd3, 1);
        add(4'b0000, 1, 0,0,0,1, 2'd3, 1);
        add(4'b0000, 1, 0,0,0,0, 2'd3, 1);
        add(4'b0000, 1, 1,0,0,0, 2'd3, 1);
        add(4'b0000, 4, 0,0,0,1, 2'd3, 1);
        add(4'b0000, 1, 0,0,0,0, 2'd3, 1);

        for (int r = 0; r < tbl.size(); r++) begin
            int e0;
            e0 = errors;
            for (int k = 0; k < tbl[r].n; k++) begin
                @(negedge clk);
                set_mask = (k == 0) ? tbl[r].set : 4'b0000;
                @(posedge clk);
                #1 check_out($sformatf("row%0d_cyc%0d", r, k), tbl[r].esc, tbl[r].ms,
                             tbl[r].md, tbl[r].pa, tbl[r].andar, tbl[r].dir);
            end
            $display("row %0d set=%b cycles=%0d andar=%0d errors_in_row=%0d",
                     r, tbl[r].set, tbl[r].n, tbl[r].andar, errors - e0);
        end

        // Reset while descending from floor 2 to floor 1.
        @(negedge clk);
        set_mask = 4'b0001;
        @(negedge clk);
        set_mask = 4'b0000;
        reached = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (andar_atual == 2'd2 && motor_descer) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL wait_descent: andar=%0d motor_descer=%b, required andar=2 descending",
                     andar_atual, motor_descer);
        end
        @(posedge clk);
        #2 reset_n = 1'b0;
        mem_flush = 1'b1;
        #1 check_out("reset_mid_travel", 0, 0, 0, 0, 2'd0, 1'b1);
        $display("reset during descent at %0t", $time);
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        mem_flush = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1 check_out($sformatf("idle_after_reset_%0d", k), 0, 0, 0, 0, 2'd0, 1'b1);
        end
        $display("idle after reset checked for 10 cycles");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
